// File: rtl/mem_access_stage_pkg.sv
// Shared definitions for the memory-access stage: control-word layout,
// access-size codes, exception vectors, FSM states and MEM/WB record.
package mem_access_stage_pkg;

  localparam int CTL_W       = 7;
  localparam int CTL_BUBBLE  = 0;
  localparam int CTL_RD      = 1;
  localparam int CTL_WR      = 2;
  localparam int CTL_SIZE_LO = 3;
  localparam int CTL_SIZE_HI = 4;
  localparam int CTL_UNS     = 5;
  localparam int CTL_RW      = 6;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;  // behaves as a word access

  localparam logic [4:0] VEC_LOAD_MISALIGN  = 5'd4;
  localparam logic [4:0] VEC_STORE_MISALIGN = 5'd5;

  typedef enum logic {ST_IDLE, ST_WAIT} state_t;

  typedef struct packed {
    logic       rw;
    logic       uns;
    logic [1:0] size;
    logic       wr;
    logic       rd;
    logic       bubble;
  } ctl_t;

  typedef struct packed {
    logic        valid;
    logic        regwrite;
    logic [31:0] data;
    logic [4:0]  regdst;
    logic [4:0]  vector;
  } wb_t;

  function automatic ctl_t decode_ctl(input logic [CTL_W-1:0] c);
    ctl_t d;
    d.bubble = c[CTL_BUBBLE];
    d.rd     = c[CTL_RD];
    d.wr     = c[CTL_WR];
    d.size   = c[CTL_SIZE_HI:CTL_SIZE_LO];
    d.uns    = c[CTL_UNS];
    d.rw     = c[CTL_RW];
    return d;
  endfunction

endpackage

// File: rtl/mem_access_stage_load_align.sv
// Load data alignment: picks the addressed byte/half lane out of the
// 32-bit read word and sign- or zero-extends it.
module mem_load_align
  import mem_access_stage_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  off,
  input  logic [1:0]  size,
  input  logic        uns,
  output logic [31:0] data
);

  logic [7:0]  lane_b;
  logic [15:0] lane_h;

  assign lane_b = rdata[{off, 3'b000} +: 8];
  assign lane_h = off[1] ? rdata[31:16] : rdata[15:0];

  // Lane select and extension by access size
  always_comb begin
    data = rdata;
    case (size)
      SZ_BYTE: data = {{24{lane_b[7] & ~uns}}, lane_b};
      SZ_HALF: data = {{16{lane_h[15] & ~uns}}, lane_h};
      SZ_WORD, SZ_RSVD: data = rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_stage.sv
// Memory stage: decodes the EX/MEM control word, runs loads/stores over a
// req/ack data-memory handshake, stalls upstream while an access is in
// flight, and registers the MEM/WB write-back record.
module mem_access_stage
  import mem_access_stage_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [6:0]        control_in,
  input  logic [31:0]       alu_in,
  input  logic [31:0]       sw_in,
  input  logic [4:0]        regdst_in,
  input  logic [4:0]        vector_ex_in,
  input  logic              mem_flush,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [3:0]        dmem_be,
  output logic [31:0]       dmem_wdata,
  input  logic [31:0]       dmem_rdata,
  input  logic              dmem_ack,
  output logic              mem_stall,
  output logic              wb_valid,
  output logic              wb_regwrite,
  output logic [31:0]       wb_data,
  output logic [4:0]        wb_regdst,
  output logic [4:0]        wb_vector
);

  ctl_t        ctl;
  state_t      state;
  wb_t         wb;
  logic        is_mem, aligned, access, start;
  logic [4:0]  exc_vec;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic [31:0] load_data;
  logic        kill;
  logic        cap_load, cap_rw, cap_uns;
  logic [1:0]  cap_off, cap_size;
  logic [4:0]  cap_regdst;

  assign ctl = decode_ctl(control_in);

  // Classify the incoming instruction: alignment, exception vector, access
  always_comb begin
    aligned = 1'b1;
    case (ctl.size)
      SZ_BYTE:          aligned = 1'b1;
      SZ_HALF:          aligned = ~alu_in[0];
      SZ_WORD, SZ_RSVD: aligned = (alu_in[1:0] == 2'b00);
    endcase
    is_mem  = ~ctl.bubble & (ctl.rd | ctl.wr);
    exc_vec = vector_ex_in;
    if (vector_ex_in == 5'd0 && is_mem && !aligned)
      exc_vec = ctl.rd ? VEC_LOAD_MISALIGN : VEC_STORE_MISALIGN;
    access = is_mem & (vector_ex_in == 5'd0) & aligned;
    // A flush in the issue cycle kills the access before it starts
    start  = access & ~mem_flush;
  end

  // Byte enables and lane-replicated store data for the issue cycle
  always_comb begin
    be    = 4'b1111;
    wdata = sw_in;
    case (ctl.size)
      SZ_BYTE: begin
        be    = 4'b0001 << alu_in[1:0];
        wdata = {4{sw_in[7:0]}};
      end
      SZ_HALF: begin
        be    = alu_in[1] ? 4'b1100 : 4'b0011;
        wdata = {2{sw_in[15:0]}};
      end
      SZ_WORD, SZ_RSVD: begin
        be    = 4'b1111;
        wdata = sw_in;
      end
    endcase
  end

  mem_load_align u_align (
    .rdata (dmem_rdata),
    .off   (cap_off),
    .size  (cap_size),
    .uns   (cap_uns),
    .data  (load_data)
  );

  // Stall drops in the ack cycle so upstream advances on the completing edge
  assign mem_stall = (state == ST_IDLE) ? start : ~dmem_ack;

  assign wb_valid    = wb.valid;
  assign wb_regwrite = wb.regwrite;
  assign wb_data     = wb.data;
  assign wb_regdst   = wb.regdst;
  assign wb_vector   = wb.vector;

  // Access FSM, registered memory request and MEM/WB record
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= ST_IDLE;
      kill       <= 1'b0;
      dmem_req   <= 1'b0;
      dmem_we    <= 1'b0;
      dmem_addr  <= '0;
      dmem_be    <= '0;
      dmem_wdata <= '0;
      cap_load   <= 1'b0;
      cap_rw     <= 1'b0;
      cap_uns    <= 1'b0;
      cap_off    <= '0;
      cap_size   <= '0;
      cap_regdst <= '0;
      wb         <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_WAIT;
            dmem_req   <= 1'b1;
            dmem_we    <= ~ctl.rd;
            dmem_addr  <= {alu_in[ADDR_W-1:2], 2'b00};
            dmem_be    <= be;
            dmem_wdata <= wdata;
            cap_load   <= ctl.rd;
            cap_rw     <= ctl.rw;
            cap_uns    <= ctl.uns;
            cap_off    <= alu_in[1:0];
            cap_size   <= ctl.size;
            cap_regdst <= regdst_in;
            wb         <= '0;
          end else if (ctl.bubble || mem_flush) begin
            wb <= '0;
          end else begin
            wb.valid    <= 1'b1;
            wb.regwrite <= ctl.rw & (exc_vec == 5'd0);
            wb.data     <= alu_in;
            wb.regdst   <= regdst_in;
            wb.vector   <= exc_vec;
          end
        end
        ST_WAIT: begin
          if (mem_flush) kill <= 1'b1;
          if (dmem_ack) begin
            state    <= ST_IDLE;
            kill     <= 1'b0;
            dmem_req <= 1'b0;
            dmem_we  <= 1'b0;
            if (kill || mem_flush) begin
              wb <= '0;
            end else begin
              // Stores retire as valid with no register write and zero data
              wb.valid    <= 1'b1;
              wb.regwrite <= cap_load & cap_rw;
              wb.data     <= cap_load ? load_data : 32'd0;
              wb.regdst   <= cap_regdst;
              wb.vector   <= 5'd0;
            end
          end else begin
            wb <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed table rows, randomized instructions
// checked against a transaction-level model, and an asynchronous reset
// asserted mid-access.
module tb_mem_access_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [6:0]  control_in;
  logic [31:0] alu_in, sw_in, dmem_rdata, dmem_wdata, wb_data, dmem_addr;
  logic [4:0]  regdst_in, vector_ex_in, wb_regdst, wb_vector;
  logic        mem_flush, dmem_req, dmem_we, dmem_ack, mem_stall;
  logic        wb_valid, wb_regwrite;
  logic [3:0]  dmem_be;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_access_stage #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset), .control_in(control_in), .alu_in(alu_in),
    .sw_in(sw_in), .regdst_in(regdst_in), .vector_ex_in(vector_ex_in),
    .mem_flush(mem_flush), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_be(dmem_be), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_ack(dmem_ack), .mem_stall(mem_stall),
    .wb_valid(wb_valid), .wb_regwrite(wb_regwrite), .wb_data(wb_data),
    .wb_regdst(wb_regdst), .wb_vector(wb_vector)
  );

  // flush: 0 none, 1 flush in the issue cycle, 2 flush in first wait cycle
  typedef struct {
    logic [6:0]  ctl;
    logic [31:0] alu;
    logic [31:0] sw;
    logic [4:0]  rd;
    logic [4:0]  vec;
    logic [31:0] rdata;
    int          waits;
    int          flush;
  } stim_t;

  typedef struct {
    bit          access;
    logic [31:0] addr;
    logic [3:0]  be;
    logic        we;
    logic [31:0] wdata;
    logic        valid;
    logic        rw;
    logic [31:0] data;
    logic [4:0]  regdst;
    logic [4:0]  vector;
  } exp_t;

  typedef struct {
    stim_t s;
    exp_t  e;
  } row_t;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, want, $time);
    end
  endtask

  // Whole-instruction reference: what the stage must do with one instruction
  function automatic exp_t model(input stim_t s);
    exp_t        e;
    bit          bub, rd, wr, uns, rw, is_mem, al;
    int          nb, off;
    logic [31:0] v, mask;
    e = '{access: 1'b0, addr: '0, be: '0, we: 1'b0, wdata: '0,
          valid: 1'b0, rw: 1'b0, data: '0, regdst: '0, vector: '0};
    bub = s.ctl[0]; rd = s.ctl[1]; wr = s.ctl[2]; uns = s.ctl[5]; rw = s.ctl[6];
    nb  = (s.ctl[4:3] == 2'd0) ? 1 : (s.ctl[4:3] == 2'd1) ? 2 : 4;
    off = int'(s.alu % 4);
    al  = (s.alu % nb) == 0;
    is_mem = rd || wr;
    if (bub || s.flush == 1) return e;
    if (is_mem && s.vec == 0 && al) begin
      e.access = 1;
      e.addr   = s.alu - off;
      e.we     = !rd;
      if (nb == 1) begin
        e.be = 4'(1 << off); e.wdata = s.sw[7:0] * 32'h01010101;
      end else if (nb == 2) begin
        e.be = (off >= 2) ? 4'hC : 4'h3; e.wdata = s.sw[15:0] * 32'h00010001;
      end else begin
        e.be = 4'hF; e.wdata = s.sw;
      end
      if (s.flush == 2) return e;
      e.valid  = 1;
      e.regdst = s.rd;
      if (rd) begin
        mask = (nb == 1) ? 32'hFF : (nb == 2) ? 32'hFFFF : 32'hFFFF_FFFF;
        v = (nb == 4) ? s.rdata : (s.rdata >> (8 * ((nb == 1) ? off : (off / 2) * 2))) & mask;
        if (!uns && nb < 4 && v[8*nb-1]) v = v | ~mask;
        e.data = v;
        e.rw   = rw;
      end
    end else begin
      e.valid  = 1;
      e.vector = (s.vec != 0) ? s.vec : (is_mem ? (rd ? 5'd4 : 5'd5) : 5'd0);
      e.rw     = rw && (e.vector == 0);
      e.data   = s.alu;
      e.regdst = s.rd;
    end
    return e;
  endfunction

  task automatic chk_wb(input string tag, input exp_t e);
    chk({tag, ".wb_valid"},    wb_valid,    e.valid);
    chk({tag, ".wb_regwrite"}, wb_regwrite, e.rw);
    chk({tag, ".wb_data"},     wb_data,     e.data);
    chk({tag, ".wb_regdst"},   wb_regdst,   e.regdst);
    chk({tag, ".wb_vector"},   wb_vector,   e.vector);
  endtask

  // Present one instruction in IDLE, play the memory side, check everything
  task automatic run(input string tag, input stim_t s, input exp_t e);
    control_in = s.ctl; alu_in = s.alu; sw_in = s.sw; regdst_in = s.rd;
    vector_ex_in = s.vec; mem_flush = (s.flush == 1); dmem_ack = 1'b0;
    #1;
    if (s.flush != 1) chk({tag, ".stall_issue"}, mem_stall, e.access);
    @(posedge clk); #1;
    mem_flush = 1'b0;
    if (!e.access) begin
      chk({tag, ".no_req"}, dmem_req, 1'b0);
      chk_wb(tag, e);
    end else begin
      chk({tag, ".req"},   dmem_req,   1'b1);
      chk({tag, ".we"},    dmem_we,    e.we);
      chk({tag, ".addr"},  dmem_addr,  e.addr);
      chk({tag, ".be"},    dmem_be,    e.be);
      chk({tag, ".wdata"}, dmem_wdata, e.wdata);
      chk({tag, ".wb_bubble"}, wb_valid, 1'b0);
      control_in = 7'h01;  // new EX/MEM contents must not disturb the access
      for (int i = 0; i < s.waits; i++) begin
        mem_flush = (s.flush == 2 && i == 0);
        #1 chk({tag, ".stall_wait"}, mem_stall, 1'b1);
        @(posedge clk); #1;
        mem_flush = 1'b0;
        chk({tag, ".req_hold"},  dmem_req,  1'b1);
        chk({tag, ".addr_hold"}, dmem_addr, e.addr);
      end
      dmem_ack = 1'b1; dmem_rdata = s.rdata;
      #1 chk({tag, ".stall_ack"}, mem_stall, 1'b0);
      @(posedge clk); #1;
      dmem_ack = 1'b0; dmem_rdata = $urandom;
      chk({tag, ".req_drop"}, dmem_req, 1'b0);
      chk_wb(tag, e);
    end
    control_in = 7'h01;
  endtask

  function automatic row_t mk(input logic [6:0] ctl, input logic [31:0] alu, input logic [31:0] sw,
                              input logic [4:0] rd, input logic [4:0] vec, input logic [31:0] rdata,
                              input int waits, input int flush, input bit acc, input logic [31:0] addr,
                              input logic [3:0] be, input logic we, input logic [31:0] wdata,
                              input logic valid, input logic rw, input logic [31:0] data,
                              input logic [4:0] regdst, input logic [4:0] vector);
    row_t r;
    r.s = '{ctl, alu, sw, rd, vec, rdata, waits, flush};
    r.e = '{acc, addr, be, we, wdata, valid, rw, data, regdst, vector};
    return r;
  endfunction

  row_t  tbl[12];
  stim_t s;
  exp_t  e;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    // ctl bits: {reg_write, unsigned, size[1:0], mem_write, mem_read, bubble}
    tbl[0]  = mk(7'h40, 32'h1234, '0, 5'd7, '0, '0, 0, 0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b1, 32'h1234, 5'd7, '0);
    tbl[1]  = mk(7'h42, 32'h103, '0, 5'd3, '0, 32'h8000_0000, 3, 0, 1'b1, 32'h100, 4'b1000, 1'b0, '0, 1'b1, 1'b1, 32'hFFFF_FF80, 5'd3, '0);
    tbl[2]  = mk(7'h62, 32'h103, '0, 5'd3, '0, 32'h8000_0000, 3, 0, 1'b1, 32'h100, 4'b1000, 1'b0, '0, 1'b1, 1'b1, 32'h0000_0080, 5'd3, '0);
    tbl[3]  = mk(7'h0C, 32'h202, 32'hABCD, 5'd9, '0, '0, 1, 0, 1'b1, 32'h200, 4'b1100, 1'b1, 32'hABCD_ABCD, 1'b1, 1'b0, '0, 5'd9, '0);
    tbl[4]  = mk(7'h52, 32'h6, '0, 5'd4, '0, '0, 0, 0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, 32'h6, 5'd4, 5'd4);
    tbl[5]  = mk(7'h14, 32'h6, '0, 5'd2, '0, '0, 0, 0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, 32'h6, 5'd2, 5'd5);
    tbl[6]  = mk(7'h52, 32'h8, '0, 5'd6, 5'd9, '0, 0, 0, 1'b0, '0, '0, 1'b0, '0, 1'b1, 1'b0, 32'h8, 5'd6, 5'd9);
    tbl[7]  = mk(7'h52, 32'h10, '0, 5'd8, '0, 32'h5555_AAAA, 2, 2, 1'b1, 32'h10, 4'hF, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    tbl[8]  = mk(7'h52, 32'h20, '0, 5'd8, '0, '0, 0, 1, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    tbl[9]  = mk(7'h41, 32'h77, '0, 5'd5, '0, '0, 0, 0, 1'b0, '0, '0, 1'b0, '0, 1'b0, 1'b0, '0, '0, '0);
    tbl[10] = mk(7'h52, 32'h40, '0, 5'd1, '0, 32'hDEAD_BEEF, 0, 0, 1'b1, 32'h40, 4'hF, 1'b0, '0, 1'b1, 1'b1, 32'hDEAD_BEEF, 5'd1, '0);
    tbl[11] = mk(7'h4A, 32'h42, '0, 5'd11, '0, 32'h8001_0000, 1, 0, 1'b1, 32'h40, 4'b1100, 1'b0, '0, 1'b1, 1'b1, 32'hFFFF_8001, 5'd11, '0);

    // Reset state
    reset = 1'b0; control_in = 7'h01; alu_in = '0; sw_in = '0; regdst_in = '0;
    vector_ex_in = '0; mem_flush = 1'b0; dmem_rdata = '0; dmem_ack = 1'b0;
    #22;
    chk("rst.req",      dmem_req,    1'b0);
    chk("rst.be",       dmem_be,     4'h0);
    chk("rst.addr",     dmem_addr,   32'h0);
    chk("rst.wb_valid", wb_valid,    1'b0);
    chk("rst.wb_data",  wb_data,     32'h0);
    @(posedge clk); #1;
    reset = 1'b1;
    #1 chk("rst.stall", mem_stall, 1'b0);

    for (int i = 0; i < 12; i++)
      run($sformatf("row%0d", i), tbl[i].s, tbl[i].e);

    // Randomized instructions against the reference model
    for (int i = 0; i < 80; i++) begin
      int kind;
      kind    = $urandom_range(0, 2);
      s.ctl   = {1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 1'(kind == 2), 1'(kind == 1), 1'($urandom_range(0, 7) == 0)};
      s.alu   = $urandom;
      s.sw    = $urandom;
      s.rd    = 5'($urandom_range(0, 31));
      s.vec   = ($urandom_range(0, 5) == 0) ? 5'($urandom_range(1, 31)) : 5'd0;
      s.rdata = $urandom;
      s.waits = $urandom_range(0, 4);
      kind    = $urandom_range(0, 9);
      s.flush = (kind == 0) ? 1 : (kind == 1 && s.waits > 0) ? 2 : 0;
      e = model(s);
      run($sformatf("rnd%0d", i), s, e);
    end

    // Asynchronous reset in the middle of an outstanding load
    run("pre_rst", tbl[0].s, tbl[0].e);
    control_in = 7'h52; alu_in = 32'h30; regdst_in = 5'd3; vector_ex_in = '0;
    @(posedge clk); #1;
    chk("midrst.req_before", dmem_req, 1'b1);
    control_in = 7'h01;
    reset = 1'b0;
    #1;
    chk("midrst.req",         dmem_req,    1'b0);
    chk("midrst.be",          dmem_be,     4'h0);
    chk("midrst.wb_valid",    wb_valid,    1'b0);
    chk("midrst.wb_regwrite", wb_regwrite, 1'b0);
    chk("midrst.wb_vector",   wb_vector,   5'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    run("post_rst", tbl[0].s, tbl[0].e);
    run("post_rst_ld", tbl[10].s, tbl[10].e);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
# mem_access_stage

Memory-stage consumer of the EX/MEM pipeline register outputs. It decodes the registered control word, runs loads and stores against the data memory through a req/ack handshake with arbitrary wait states, and stalls upstream stages while an access is outstanding. It aligns and extends load data, checks alignment, and registers the MEM/WB values: write-back data, destination register and exception vector.

## Interface
Parameters:
- ADDR_W, 32, data-memory address width; data path fixed at 32 bits.

Ports:
- clk  in  1  clock.
- reset  in  1  reset, asynchronous, active-low.
- control_in  in  7  EX/MEM control word.
  - [0] bubble
  - [1] mem_read
  - [2] mem_write
  - [4:3] size: 00 byte, 01 half, 10 word, 11 treated as word
  - [5] load_unsigned
  - [6] reg_write
- alu_in  in  32  ALU result; effective address for memory ops.
- sw_in  in  32  store data.
- regdst_in  in  5  destination register.
- vector_ex_in  in  5  upstream exception vector; 0 means none.
- mem_flush  in  1  synchronous kill of the instruction in this stage.
- dmem_req  out  1  memory request.
- dmem_we  out  1  1 = store.
- dmem_addr  out  ADDR_W  word-aligned address (alu_in with [1:0] forced to 0).
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-replicated store data.
- dmem_rdata  in  32  read data; valid with dmem_ack.
- dmem_ack  in  1  access complete.
- mem_stall  out  1  holds the EX/MEM register and all earlier stages.
- wb_valid  out  1  MEM/WB holds a real instruction.
- wb_regwrite  out  1  write-back enable.
- wb_data  out  32  write-back value.
- wb_regdst  out  5  write-back register.
- wb_vector  out  5  exception vector.

## Operation
An input is an "access" when all of these hold:
- bubble = 0
- mem_read or mem_write = 1
- vector_ex_in = 0
- the address is aligned: half needs a[0] = 0; word needs a[1:0] = 0

Misalignment handling:
- Misaligned load: set wb_vector = 5'd4.
- Misaligned store: set wb_vector = 5'd5.
- In both cases issue no memory request and force wb_regwrite = 0.
- A nonzero vector_ex_in always passes through unchanged and suppresses the access.

State machine, states IDLE and WAIT:
- IDLE with a non-access: register MEM/WB in one cycle.
  - wb_data = alu_in
  - wb_regwrite = reg_write & ~bubble & (wb_vector == 0)
  - wb_valid = ~bubble
- IDLE with an access: capture address, size, unsigned flag, regdst and store data, then go to WAIT. MEM/WB loads a bubble on this edge.
- WAIT: dmem_req = 1.
  - dmem_we, dmem_addr, dmem_be and dmem_wdata are registered and held stable until ack.
  - On dmem_ack, write MEM/WB and return to IDLE.
  - A load writes the extended data; a store writes wb_regwrite = 0, wb_valid = 1.
- dmem_ack in IDLE is ignored.

Byte enables and store data:
- Byte: be = 1 << a[1:0]; wdata = byte replicated x4.
- Half: be = 4'b0011 or 4'b1100 by a[1]; wdata = half replicated x2.
- Word: be = 4'b1111.

Load extension:
- Select the lane by a[1:0].
- Sign-extend, or zero-extend when load_unsigned = 1.

mem_stall:
- Combinational: (IDLE & access) | (WAIT & ~dmem_ack).

mem_flush:
- In IDLE: MEM/WB loads a bubble and the access is not started.
- In WAIT: sets a sticky kill. The memory transaction still completes, and on ack MEM/WB loads a bubble. The kill clears on return to IDLE.

Bubble value:
- wb_valid = 0, wb_regwrite = 0, wb_data = 0, wb_regdst = 0, wb_vector = 0.

## Timing
- Reset (asynchronous, any state, including mid-WAIT):
  - state = IDLE, kill = 0
  - dmem_req = 0, dmem_we = 0, dmem_be = 0
  - dmem_addr = 0, dmem_wdata = 0
  - all wb_* = 0
  - mem_stall = 0 once reset is released
- Non-access latency: 1 cycle, input to wb_* outputs.
- Access latency: the edge that enters WAIT is cycle 0; dmem_req is high from cycle 1. The MEM/WB update is on the edge where dmem_ack = 1, so the minimum is 2 cycles with a zero-wait memory that acks at cycle 1.
- mem_stall falls in the same cycle that dmem_ack is high, so upstream advances on that edge.
- dmem_req drops on the edge after ack.
- Back-to-back accesses: IDLE for one cycle between accesses is required; it is the issue cycle.

## Structure
Shared package holds:
- control-word bit indices
- size encodings
- vector codes 5'd4 and 5'd5
- the state enum

One sub-module is natural: mem_load_align, a combinational lane select and sign/zero extend of (rdata, a[1:0], size, unsigned) to 32 bits.

## Test plan
- Non-memory op, alu_in = 32'h1234, reg_write = 1, regdst = 7 → next cycle wb_data = 32'h1234, wb_regdst = 7, wb_regwrite = 1, mem_stall = 0 throughout.
- Signed byte load at addr 32'h103, memory returns 32'h80000000 after 3 wait cycles → dmem_be = 4'b1000; mem_stall high for 4 cycles; wb_data = 32'hFFFFFF80. Repeat with load_unsigned = 1 → wb_data = 32'h00000080.
- Halfword store at addr 32'h202, sw_in = 32'hABCD → dmem_we = 1, dmem_be = 4'b1100, dmem_wdata = 32'hABCDABCD, dmem_addr = 32'h200; wb_regwrite = 0.
- Word load at addr 32'h6 → no dmem_req, wb_vector = 5'd4, wb_regwrite = 0. Word store at addr 32'h6 → no dmem_req, wb_vector = 5'd5. Input vector 5'd9 on a load → no request, wb_vector = 5'd9.
- mem_flush during WAIT → request held until ack, then MEM/WB loads a bubble. mem_flush in IDLE with an access → no dmem_req.
- reset asserted mid-WAIT → dmem_req = 0 and all wb_* = 0 immediately. After release, a non-access completes in 1 cycle.
